inst_rom_ctrl: RTL and testbench

Instruction-memory responder on the fetch side of the pipeline. It accepts a word fetch address from the IF stage and returns the 32-bit instruction. Each word is assembled little-endian from four reads on a byte-wide external memory port, and the last fetched word is held in a one-entry buffer. While a word is not yet available it raises a stall request toward the pipeline controller.

---
 rtl/inst_rom_ctrl_pkg.sv | 21 ++
 rtl/inst_rom_ctrl_if.sv | 26 ++
 rtl/imem_byte_assembler.sv | 36 +++
 rtl/inst_rom_ctrl.sv | 163 ++++++++++++++++
 tb/tb_inst_rom_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/inst_rom_ctrl_pkg.sv
// Purpose : shared types and constants for the instruction-memory fetch responder.
// Latency : n/a (declarations only).
// Backpressure: n/a. Contents: ZeroWord, instruction/address bus types, FSM state encoding.
package inst_rom_ctrl_pkg;

   localparam int InstBusW     = 32;
   localparam int InstAddrBusW = 32;

   typedef logic [InstBusW-1:0]     inst_t;
   typedef logic [InstAddrBusW-1:0] inst_addr_t;

   localparam inst_t ZeroWord = '0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH    = 2'd1,
      ABORT    = 2'd2,
      PREFETCH = 2'd3
   } state_e;

endpackage

// File: rtl/inst_rom_ctrl_if.sv
// Purpose : bundles the IF-side fetch port and the byte-wide external memory port.
// Latency : n/a (wires only).
// Backpressure: stall_req toward IF; mem_valid paces the memory side.
// Modports: slave = the controller, master = IF stage plus memory (environment).
interface inst_rom_ctrl_if import inst_rom_ctrl_pkg::*; #(parameter int ADDR_W = 17);

   logic              rom_ce_i;
   inst_addr_t        rom_addr_i;
   inst_t             rom_data_o;
   logic              stall_req_o;
   logic              mem_rd_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [7:0]        mem_data_i;
   logic              mem_valid_i;

   modport slave (
      input  rom_ce_i, rom_addr_i, mem_data_i, mem_valid_i,
      output rom_data_o, stall_req_o, mem_rd_o, mem_addr_o
   );

   modport master (
      output rom_ce_i, rom_addr_i, mem_data_i, mem_valid_i,
      input  rom_data_o, stall_req_o, mem_rd_o, mem_addr_o
   );

endinterface

// File: rtl/imem_byte_assembler.sv
// Purpose : collects four bytes into a little-endian word; holds byte index k.
// Latency : word/done are combinational on the cycle the 4th byte is accepted.
// Backpressure: none; advances only on take, clr restarts at byte 0.
// Ports: clk, rst_n, clr, take, byte_in -> k, word, done.
module imem_byte_assembler
   import inst_rom_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       take,
   input  logic [7:0] byte_in,
   output logic [1:0] k,
   output inst_t      word,
   output logic       done
);

   // Bytes 0..2 shift in from the top so that byte 0 ends up in lane 0.
   logic [23:0] lanes;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k     <= 2'd0;
         lanes <= '0;
      end else if (clr) begin
         k <= 2'd0;
      end else if (take) begin
         k     <= k + 2'd1;   // wraps to 0 after byte 3
         lanes <= {byte_in, lanes[23:8]};
      end
   end

   assign word = {byte_in, lanes};
   assign done = take & (k == 2'd3);

endmodule

// File: rtl/inst_rom_ctrl.sv
// Purpose : instruction fetch responder with a one-word buffer over a byte-wide memory.
// Latency : hit 0 cycles; miss 5 cycles at zero-wait memory, +1 per memory wait cycle.
// Backpressure: stall_req_o high while the requested word is not buffered.
// Ports: clk, rst_n, bus (inst_rom_ctrl_if.slave). Optional macro IMEM_PREFETCH_EN adds a
// second (next-sequential) buffer entry filled in the background.
module inst_rom_ctrl
   import inst_rom_ctrl_pkg::*;
#(
   parameter int ADDR_W = 17
) (
   input logic              clk,
   input logic              rst_n,
   inst_rom_ctrl_if.slave   bus
);

   localparam logic [ADDR_W-1:0] WordStep = ADDR_W'(4);

   state_e            state;
   logic [ADDR_W-1:0] wa, cur_addr, buf_addr, mem_addr;
   inst_t             buf_data, asm_word;
   logic              buf_vld, mem_rd;
   logic              hit_buf, hit, miss, take, abandon, fill_take, asm_done;
   logic [1:0]        k;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{bus.rom_addr_i[InstAddrBusW-1:ADDR_W], bus.rom_addr_i[1:0]};

   assign wa      = {bus.rom_addr_i[ADDR_W-1:2], 2'b00};
   assign hit_buf = bus.rom_ce_i & buf_vld & (wa == buf_addr);

`ifdef IMEM_PREFETCH_EN
   logic [ADDR_W-1:0] pf_addr;
   inst_t             pf_data;
   logic              pf_vld, hit_pf;
   assign hit_pf = bus.rom_ce_i & pf_vld & (wa == pf_addr);
   assign hit    = hit_buf | hit_pf;
`else
   assign hit    = hit_buf;
`endif

   // rom_ce_i is ignored while reset is held.
   assign miss            = rst_n & bus.rom_ce_i & ~hit;
   assign bus.stall_req_o = miss;
   assign bus.mem_rd_o    = mem_rd;
   assign bus.mem_addr_o  = mem_addr;
   assign take            = mem_rd & bus.mem_valid_i;

   always_comb begin
      bus.rom_data_o = ZeroWord;
      if (hit_buf) bus.rom_data_o = buf_data;
`ifdef IMEM_PREFETCH_EN
      else if (hit_pf) bus.rom_data_o = pf_data;
`endif
   end

   // A demand fill is dropped on any redirect/flush; a prefetch is dropped only when
   // IF misses on some other address (a miss on the prefetch target just waits for it).
   always_comb begin
      abandon = 1'b0;
      if (state == FETCH) abandon = ~bus.rom_ce_i | (wa != cur_addr);
`ifdef IMEM_PREFETCH_EN
      if (state == PREFETCH) abandon = miss & (wa != cur_addr);
`endif
   end

   assign fill_take = take & ~abandon & ((state == FETCH) | (state == PREFETCH));

   imem_byte_assembler u_asm (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (abandon),
      .take    (fill_take),
      .byte_in (bus.mem_data_i),
      .k       (k),
      .word    (asm_word),
      .done    (asm_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cur_addr <= '0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         buf_addr <= '0;
         buf_data <= ZeroWord;
         buf_vld  <= 1'b0;
`ifdef IMEM_PREFETCH_EN
         pf_addr  <= '0;
         pf_data  <= ZeroWord;
         pf_vld   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (miss) begin
                  cur_addr <= wa;
                  mem_addr <= wa;
                  mem_rd   <= 1'b1;
                  state    <= FETCH;
               end
`ifdef IMEM_PREFETCH_EN
               else if (hit_pf) begin
                  // Promote the prefetched word and run ahead by one more word.
                  buf_addr <= pf_addr;
                  buf_data <= pf_data;
                  buf_vld  <= 1'b1;
                  pf_vld   <= 1'b0;
                  cur_addr <= pf_addr + WordStep;
                  mem_addr <= pf_addr + WordStep;
                  mem_rd   <= 1'b1;
                  state    <= PREFETCH;
               end
`endif
            end
            ABORT: begin
               // Drain the one outstanding byte; its data is discarded.
               if (bus.mem_valid_i) begin
                  mem_rd <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin // FETCH and PREFETCH
               if (abandon) begin
                  if (take) begin
                     mem_rd <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     state  <= ABORT;
                  end
               end else if (asm_done) begin
`ifdef IMEM_PREFETCH_EN
                  if (state == PREFETCH) begin
                     pf_addr <= cur_addr;
                     pf_data <= asm_word;
                     pf_vld  <= 1'b1;
                     mem_rd  <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     buf_addr <= cur_addr;
                     buf_data <= asm_word;
                     buf_vld  <= 1'b1;
                     pf_vld   <= 1'b0;
                     cur_addr <= cur_addr + WordStep;
                     mem_addr <= cur_addr + WordStep;
                     state    <= PREFETCH;
                  end
`else
                  buf_addr <= cur_addr;
                  buf_data <= asm_word;
                  buf_vld  <= 1'b1;
                  mem_rd   <= 1'b0;
                  state    <= IDLE;
`endif
               end else if (take) begin
                  mem_addr <= cur_addr + ADDR_W'(k) + ADDR_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Purpose : self-checking bench for inst_rom_ctrl (default build, single buffer entry).
// Latency : n/a.
// Backpressure: memory model answers mem_rd_o after wait_cfg idle cycles per byte.
module tb_inst_rom_ctrl;
   import inst_rom_ctrl_pkg::*;

   localparam int AW = 17;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   inst_rom_ctrl_if #(.ADDR_W(AW)) bus ();

   inst_rom_ctrl #(.ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Byte memory model: valid after wait_cfg cycles of a held request.
   logic [7:0]    mem [0:511];
   int            wait_cfg = 0;
   int            wcnt     = 0;
   logic [AW-1:0] taken [$];
   logic [AW-1:0] exp_q [$];

   assign bus.mem_valid_i = bus.mem_rd_o & (wcnt == wait_cfg);
   assign bus.mem_data_i  = mem[bus.mem_addr_o[8:0]];

   always @(posedge clk) begin
      if (bus.mem_rd_o & bus.mem_valid_i) taken.push_back(bus.mem_addr_o);
      if (!rst_n || !bus.mem_rd_o || bus.mem_valid_i) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_taken(input string name);
      chk({name, "_count"}, 32'(taken.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < taken.size(); i++)
         chk($sformatf("%s_addr%0d", name, i), 32'(taken[i]), 32'(exp_q[i]));
   endtask

   typedef struct {
      logic        rst;
      logic        ce;
      logic [31:0] addr;
      logic        exp_stall;
      logic [31:0] exp_data;
      logic        exp_rd;
      logic        chk_a;
      logic [31:0] exp_maddr;
   } vec_t;

   vec_t vecs [10];
   int   cnt, stable_bad;
   logic prev_hold;
   logic [AW-1:0] prev_addr;

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      mem[9'h010] = 8'h13; mem[9'h011] = 8'h05; mem[9'h012] = 8'h10; mem[9'h013] = 8'h00;
      mem[9'h020] = 8'hAA; mem[9'h021] = 8'hBB; mem[9'h022] = 8'hCC; mem[9'h023] = 8'hDD;
      mem[9'h030] = 8'hB3; mem[9'h031] = 8'h85; mem[9'h032] = 8'hC5; mem[9'h033] = 8'h00;
      mem[9'h040] = 8'h37; mem[9'h041] = 8'h15; mem[9'h042] = 8'h00; mem[9'h043] = 8'h00;
      mem[9'h050] = 8'h01; mem[9'h051] = 8'h02; mem[9'h052] = 8'h03; mem[9'h053] = 8'h04;

      //            rst   ce    addr    stall data          rd    chk_a maddr
      vecs[0] = '{1'b0, 1'b1, 32'h10, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0 };
      vecs[1] = '{1'b1, 1'b0, 32'h10, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0 };
      vecs[2] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0,        1'b0, 1'b1, 32'h0 };
      vecs[3] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0,        1'b1, 1'b1, 32'h10};
      vecs[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0,        1'b1, 1'b1, 32'h11};
      vecs[5] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0,        1'b1, 1'b1, 32'h12};
      vecs[6] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0,        1'b1, 1'b1, 32'h13};
      vecs[7] = '{1'b1, 1'b1, 32'h10, 1'b0, 32'h00100513, 1'b0, 1'b0, 32'h0 };
      vecs[8] = '{1'b1, 1'b1, 32'h12, 1'b0, 32'h00100513, 1'b0, 1'b0, 32'h0 };
      vecs[9] = '{1'b1, 1'b0, 32'h12, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0 };

      bus.rom_ce_i   = 1'b0;
      bus.rom_addr_i = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state, cold miss, hit with ignored low address bits, idle.
      for (int i = 0; i < 10; i++) begin
         rst_n          = vecs[i].rst;
         bus.rom_ce_i   = vecs[i].ce;
         bus.rom_addr_i = vecs[i].addr;
         @(negedge clk);
         chk($sformatf("vec%0d_stall", i), 32'(bus.stall_req_o), 32'(vecs[i].exp_stall));
         chk($sformatf("vec%0d_data", i), bus.rom_data_o, vecs[i].exp_data);
         chk($sformatf("vec%0d_rd", i), 32'(bus.mem_rd_o), 32'(vecs[i].exp_rd));
         if (vecs[i].chk_a)
            chk($sformatf("vec%0d_maddr", i), 32'(bus.mem_addr_o), vecs[i].exp_maddr);
         @(posedge clk);
         #1;
      end

      // Redirect 0x20 -> 0x40 while byte 0x21 is outstanding.
      wait_cfg = 1;
      taken.delete();
      bus.rom_ce_i   = 1'b1;
      bus.rom_addr_i = 32'h20;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (taken.size() >= 1) break;
      end
      bus.rom_addr_i = 32'h40;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!bus.stall_req_o) break;
      end
      chk("redir_stall_clear", 32'(bus.stall_req_o), 32'h0);
      chk("redir_data", bus.rom_data_o, 32'h00001537);
      exp_q = '{17'h20, 17'h21, 17'h40, 17'h41, 17'h42, 17'h43};
      chk_taken("redir");
      @(posedge clk); #1;
      bus.rom_addr_i = 32'h20;
      @(negedge clk);
      chk("redir_old_not_buffered", 32'(bus.stall_req_o), 32'h1);
      chk("redir_old_data", bus.rom_data_o, 32'h0);
      @(posedge clk); #1;
      bus.rom_ce_i = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      // Two wait cycles per byte: 1 + 4*3 stall cycles, address held during waits.
      wait_cfg = 2;
      taken.delete();
      bus.rom_ce_i   = 1'b1;
      bus.rom_addr_i = 32'h30;
      cnt = 0; stable_bad = 0; prev_hold = 1'b0; prev_addr = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (prev_hold && bus.mem_addr_o !== prev_addr) stable_bad++;
         prev_hold = bus.mem_rd_o & ~bus.mem_valid_i;
         prev_addr = bus.mem_addr_o;
         if (!bus.stall_req_o) break;
         cnt++;
      end
      chk("wait_stall_cycles", 32'(cnt), 32'd13);
      chk("wait_data", bus.rom_data_o, 32'h00C585B3);
      chk("wait_addr_stable", 32'(stable_bad), 32'h0);
      exp_q = '{17'h30, 17'h31, 17'h32, 17'h33};
      chk_taken("wait");

      // Reset mid-fetch with byte 1 outstanding.
      @(posedge clk); #1;
      bus.rom_ce_i = 1'b0;
      wait_cfg = 3;
      @(posedge clk); #1;
      taken.delete();
      bus.rom_ce_i   = 1'b1;
      bus.rom_addr_i = 32'h50;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (taken.size() >= 1) break;
      end
      chk("rst_pre_rd", 32'(bus.mem_rd_o), 32'h1);
      chk("rst_pre_maddr", 32'(bus.mem_addr_o), 32'h51);
      rst_n = 1'b0;
      #1;
      chk("rst_rd", 32'(bus.mem_rd_o), 32'h0);
      chk("rst_maddr", 32'(bus.mem_addr_o), 32'h0);
      chk("rst_stall", 32'(bus.stall_req_o), 32'h0);
      chk("rst_data", bus.rom_data_o, 32'h0);
      @(posedge clk); #1;
      bus.rom_ce_i = 1'b0;
      rst_n        = 1'b1;
      @(negedge clk);
      chk("rst_release_stall", 32'(bus.stall_req_o), 32'h0);
      chk("rst_release_rd", 32'(bus.mem_rd_o), 32'h0);
      @(posedge clk); #1;
      bus.rom_ce_i   = 1'b1;
      bus.rom_addr_i = 32'h30;
      @(negedge clk);
      chk("rst_buf_cleared_stall", 32'(bus.stall_req_o), 32'h1);
      chk("rst_buf_cleared_data", bus.rom_data_o, 32'h0);
      @(posedge clk); #1;
      bus.rom_ce_i = 1'b0;
      repeat (10) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
